// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter: host-priority arbiter for the single-port data memory.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int HOST_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    output logic [3:0]        streak
);

    localparam logic [3:0] c_burst_max = 4'(HOST_BURST_MAX);

    logic [3:0] r_streak;
    logic       w_core_wins;
    logic       w_host_wins;

    // Core only wins a contended cycle once the host has used up its burst.
    assign w_core_wins = core_req & (~host_req | (r_streak == c_burst_max));
    assign w_host_wins = host_req & ~w_core_wins;

    assign core_stall = core_req & ~w_core_wins;
    assign host_gnt   = w_host_wins;
    assign core_rdata = (w_core_wins & ~core_we) ? mem_q : '0;
    assign streak     = r_streak;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        mem_rden  = 1'b0;
        if (w_core_wins) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_wren  = core_we;
            mem_rden  = ~core_we;
        end else if (w_host_wins) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wren  = host_we;
            mem_rden  = ~host_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= 4'd0;
        end else if (w_host_wins & core_req) begin
            if (r_streak != c_burst_max) begin
                r_streak <= r_streak + 4'd1;
            end
        end else begin
            r_streak <= 4'd0;
        end
    end

    // Memory answers within the grant cycle, so the host read is captured here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= w_host_wins & ~host_we;
            if (w_host_wins & ~host_we) begin
                host_rdata <= mem_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage ("core") and an external host/loader port ("host") used for program data preload and debug readback.
- Host has default priority. A streak counter guarantees the core a grant after HOST_BURST_MAX consecutive contended host grants.
- Drives core_stall, which the top level inverts into the pipeline register enable.
- Sits between the EX/MEM pipeline register and dataMemory. dataMemory is clocked on ~clk, so read data is valid in the same cycle as the access.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory data width.
- HOST_BURST_MAX, 4, maximum consecutive host grants while the core is waiting. Legal range 1..15.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- core_req  in  1  core access request (memRead | memWrite of the MEM stage).
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_rdata  out  DATA_W  core read data, same cycle as the grant.
- core_stall  out  1  core request not serviced this cycle.
- host_req  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rvalid  out  1  registered pulse: host_rdata is valid.
- host_rdata  out  DATA_W  registered host read data.
- mem_addr  out  ADDR_W  to dataMemory address.
- mem_wdata  out  DATA_W  to dataMemory data.
- mem_wren  out  1  to dataMemory wren.
- mem_rden  out  1  to dataMemory rden.
- mem_q  in  DATA_W  from dataMemory q.
- streak  out  4  current host streak count, for debug.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - Registered: streak = 0, host_rvalid = 0, host_rdata = 0.
  - Combinational, with all requests low: core_stall = 0, host_gnt = 0, mem_wren = 0, mem_rden = 0, mem_addr = 0, mem_wdata = 0, core_rdata = 0.
- Arbitration is combinational in the current cycle; at most one access per cycle.
  - Only core_req: core wins.
  - Only host_req: host wins.
  - Both requesting, streak < HOST_BURST_MAX: host wins.
  - Both requesting, streak == HOST_BURST_MAX: core wins.
  - Neither requesting: idle. mem_wren = mem_rden = 0; mem_addr and mem_wdata hold 0.
- Winner drive:
  - mem_addr and mem_wdata come from the winner.
  - mem_wren = winner_we; mem_rden = ~winner_we.
- core_stall = core_req & ~core_wins.
- host_gnt = host_req & host_wins.
- core_rdata = mem_q when the core wins a read, else 0.
- Streak update at the rising edge:
  - Host wins while core_req = 1: streak increments, saturating at HOST_BURST_MAX.
  - Core wins, or core_req = 0: streak clears to 0.
- Host read pipeline:
  - Host read granted in cycle t: at the edge ending t, host_rdata <= mem_q and host_rvalid <= 1.
  - host_rvalid is 1 for exactly cycle t+1, then 0 unless another host read was granted in t+1.
  - host_rdata holds its value until the next host read.
- Host write granted: no host_rvalid pulse.
- Host protocol: the host holds host_req and its fields stable until it samples host_gnt = 1. The arbiter does not buffer requests.
- Core protocol: while core_stall = 1, the pipeline is frozen, so core inputs stay stable.
- Same-address conflict (host write vs. core read): host wins, core stalls. The core's read in the next cycle returns the newly written value; no bypass path exists.
- Reset mid-operation: rst asserted in any cycle immediately forces the registered values above. A host read granted in the reset cycle produces no rvalid.
- A stall never starves: the core waits at most HOST_BURST_MAX consecutive cycles.

Test Plan:
- Reset: rst = 1 with both requests high -> streak = 0, host_rvalid = 0. After release, host wins the first contended cycle.
- Core only: core write addr 0x10, data 0x0000_00AA, then core read 0x10 -> core_stall = 0 both cycles; mem_wren = 1 then mem_rden = 1; core_rdata = 0xAA in the read cycle.
- Host read latency: preload addr 0x20 = 0xDEAD_BEEF, host read 0x20 in cycle t -> host_gnt = 1 in t; host_rvalid = 1 and host_rdata = 0xDEADBEEF in t+1 only.
- Starvation bound: HOST_BURST_MAX = 4, host_req and core_req held high -> host_gnt in cycles 0-3 with streak 1..4; core wins cycle 4 (core_stall = 0, streak -> 0); host resumes in cycle 5.
- Conflict ordering: host write 0x30 = 0x1234 and core read 0x30 in the same cycle -> core_stall = 1. Next cycle core_rdata = 0x1234.
- Mid-op reset: host read granted, rst pulsed in the same cycle -> host_rvalid stays 0 and host_rdata = 0 afterward.
